// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/write-back
// over a shared ALU and memory port, with a memory-ready timeout and a sticky trap.
module multicycle_control_unit #(
  parameter int OP_CODE_WIDTH = 7,
  parameter int FUNCT3_WIDTH  = 3,
  parameter int FUNCT7_WIDTH  = 7,
  parameter int MEM_TIMEOUT   = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [OP_CODE_WIDTH-1:0] i_op_code,
  input  logic [FUNCT3_WIDTH-1:0]  i_funct3,
  input  logic [FUNCT7_WIDTH-1:0]  i_funct7,
  input  logic                     i_alu_zero_flag,
  input  logic                     i_mem_ready,
  output logic                     o_pc_wr_en,
  output logic                     o_ir_wr_en,
  output logic                     o_adr_sel,
  output logic                     o_mem_rd_en,
  output logic                     o_mem_wr_en,
  output logic                     o_reg_file_wr_en,
  output logic [1:0]               o_imm_sel,
  output logic [1:0]               o_alu_src_a_sel,
  output logic [1:0]               o_alu_src_b_sel,
  output logic [3:0]               o_alu_ctrl,
  output logic [1:0]               o_wb_result_sel,
  output logic                     o_instr_retired,
  output logic                     o_illegal_instr,
  output logic                     o_mem_fault
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

  localparam logic [OP_CODE_WIDTH-1:0] OP_LOAD   = OP_CODE_WIDTH'(7'b0000011);
  localparam logic [OP_CODE_WIDTH-1:0] OP_STORE  = OP_CODE_WIDTH'(7'b0100011);
  localparam logic [OP_CODE_WIDTH-1:0] OP_R      = OP_CODE_WIDTH'(7'b0110011);
  localparam logic [OP_CODE_WIDTH-1:0] OP_I      = OP_CODE_WIDTH'(7'b0010011);
  localparam logic [OP_CODE_WIDTH-1:0] OP_BRANCH = OP_CODE_WIDTH'(7'b1100011);
  localparam logic [OP_CODE_WIDTH-1:0] OP_JAL    = OP_CODE_WIDTH'(7'b1101111);
  localparam logic [OP_CODE_WIDTH-1:0] OP_JALR   = OP_CODE_WIDTH'(7'b1100111);
  localparam logic [FUNCT3_WIDTH-1:0]  F3_BEQ    = FUNCT3_WIDTH'(0);
  localparam logic [FUNCT3_WIDTH-1:0]  F3_BNE    = FUNCT3_WIDTH'(1);

  localparam logic [1:0] IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11;
  localparam logic [1:0] A_PC = 2'b00, A_OLD_PC = 2'b01, A_RS1 = 2'b10;
  localparam logic [1:0] B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;
  localparam logic [1:0] WB_MDR = 2'b00, WB_ALUOUT = 2'b01, WB_ALU = 2'b10;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JALR, S_JAL, S_TRAP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_illegal;
  logic            r_mem_fault;
  logic            w_set_illegal;
  logic            w_set_fault;
  logic [CW-1:0]   r_wait_cnt;
  logic            w_waiting;
  logic            w_timeout;
  logic            w_unused;

  assign w_unused  = ^{i_funct7[FUNCT7_WIDTH-1:6], i_funct7[4:0]};
  assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);
  assign w_timeout = (MEM_TIMEOUT != 0) && !i_mem_ready && (r_wait_cnt == LIMIT);

  // funct7[5] selects SUB only for R-type; SRA/SRAI honour it for both forms.
  function automatic logic [3:0] f_alu_op(input logic [2:0] f3, input logic alt, input logic is_r);
    case (f3)
      3'b000:  return (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_FETCH;
      r_illegal   <= 1'b0;
      r_mem_fault <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) r_illegal   <= 1'b1;
      if (w_set_fault)   r_mem_fault <= 1'b1;
      // Any state change restarts the wait count, covering entry to every wait state.
      if (w_next != r_state)
        r_wait_cnt <= '0;
      else if (w_waiting && !i_mem_ready && (MEM_TIMEOUT != 0))
        r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign o_illegal_instr = r_illegal & ~i_reset;
  assign o_mem_fault     = r_mem_fault & ~i_reset;

  always_comb begin
    w_next           = r_state;
    w_set_illegal    = 1'b0;
    w_set_fault      = 1'b0;
    o_pc_wr_en       = 1'b0;
    o_ir_wr_en       = 1'b0;
    o_adr_sel        = 1'b0;
    o_mem_rd_en      = 1'b0;
    o_mem_wr_en      = 1'b0;
    o_reg_file_wr_en = 1'b0;
    o_imm_sel        = IMM_I;
    o_alu_src_a_sel  = A_PC;
    o_alu_src_b_sel  = B_RS2;
    o_alu_ctrl       = ALU_ADD;
    o_wb_result_sel  = WB_MDR;
    o_instr_retired  = 1'b0;
    if (!i_reset) begin
      case (r_state)
        S_FETCH: begin
          o_mem_rd_en     = 1'b1;
          o_alu_src_b_sel = B_FOUR;
          o_wb_result_sel = WB_ALU;
          if (i_mem_ready) begin
            o_ir_wr_en = 1'b1;
            o_pc_wr_en = 1'b1;
            w_next     = S_DECODE;
          end else if (w_timeout) begin
            w_next      = S_TRAP;
            w_set_fault = 1'b1;
          end
        end
        S_DECODE: begin
          o_alu_src_a_sel = A_OLD_PC;
          o_alu_src_b_sel = B_IMM;
          o_imm_sel       = (i_op_code == OP_JAL) ? IMM_J : IMM_B;
          if (i_op_code == OP_LOAD || i_op_code == OP_STORE)
            w_next = S_MEM_ADR;
          else if (i_op_code == OP_R)
            w_next = S_EXEC_R;
          else if (i_op_code == OP_I)
            w_next = S_EXEC_I;
          else if (i_op_code == OP_BRANCH && (i_funct3 == F3_BEQ || i_funct3 == F3_BNE))
            w_next = S_BRANCH;
          else if (i_op_code == OP_JAL)
            w_next = S_JAL;
          else if (i_op_code == OP_JALR && i_funct3 == F3_BEQ)
            w_next = S_JALR;
          else begin
            w_next        = S_TRAP;
            w_set_illegal = 1'b1;
          end
        end
        S_MEM_ADR: begin
          o_alu_src_a_sel = A_RS1;
          o_alu_src_b_sel = B_IMM;
          o_imm_sel       = (i_op_code == OP_STORE) ? IMM_S : IMM_I;
          w_next          = (i_op_code == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
        end
        S_MEM_READ: begin
          o_adr_sel   = 1'b1;
          o_mem_rd_en = 1'b1;
          if (i_mem_ready)
            w_next = S_MEM_WB;
          else if (w_timeout) begin
            w_next      = S_TRAP;
            w_set_fault = 1'b1;
          end
        end
        S_MEM_WB: begin
          o_reg_file_wr_en = 1'b1;
          o_wb_result_sel  = WB_MDR;
          o_instr_retired  = 1'b1;
          w_next           = S_FETCH;
        end
        S_MEM_WRITE: begin
          o_adr_sel   = 1'b1;
          o_mem_wr_en = 1'b1;
          if (i_mem_ready) begin
            o_instr_retired = 1'b1;
            w_next          = S_FETCH;
          end else if (w_timeout) begin
            w_next      = S_TRAP;
            w_set_fault = 1'b1;
          end
        end
        S_EXEC_R: begin
          o_alu_src_a_sel = A_RS1;
          o_alu_src_b_sel = B_RS2;
          o_alu_ctrl      = f_alu_op(i_funct3[2:0], i_funct7[5], 1'b1);
          w_next          = S_ALU_WB;
        end
        S_EXEC_I: begin
          o_alu_src_a_sel = A_RS1;
          o_alu_src_b_sel = B_IMM;
          o_imm_sel       = IMM_I;
          o_alu_ctrl      = f_alu_op(i_funct3[2:0], i_funct7[5], 1'b0);
          w_next          = S_ALU_WB;
        end
        S_ALU_WB: begin
          o_reg_file_wr_en = 1'b1;
          o_wb_result_sel  = WB_ALUOUT;
          o_instr_retired  = 1'b1;
          w_next           = S_FETCH;
        end
        S_BRANCH: begin
          o_alu_src_a_sel = A_RS1;
          o_alu_src_b_sel = B_RS2;
          o_alu_ctrl      = ALU_SUB;
          o_wb_result_sel = WB_ALUOUT;
          o_pc_wr_en      = (i_funct3 == F3_BEQ) ? i_alu_zero_flag : ~i_alu_zero_flag;
          o_instr_retired = 1'b1;
          w_next          = S_FETCH;
        end
        S_JALR: begin
          o_alu_src_a_sel = A_RS1;
          o_alu_src_b_sel = B_IMM;
          o_imm_sel       = IMM_I;
          w_next          = S_JAL;
        end
        S_JAL: begin
          o_alu_src_a_sel = A_OLD_PC;
          o_alu_src_b_sel = B_FOUR;
          o_wb_result_sel = WB_ALUOUT;
          o_pc_wr_en      = 1'b1;
          w_next          = S_ALU_WB;
        end
        default: w_next = S_TRAP;
      endcase
    end
  end

endmodule
